// File: rtl/mfb_frame_gen_pkg.sv
// mfb_frame_gen_pkg: shared types and helpers for the MFB frame generator.
//   - SOF_POS / EOF_POS field width functions
//   - LFSR tap mask and a multi-step advance helper
//   - generator FSM state enum
package mfb_frame_gen_pkg;

    // Right-shifting Fibonacci register: feedback from bits 0,2,3,5
    // realises x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int sof_pos_w(input int region_size);
        return (region_size > 1) ? $clog2(region_size) : 1;
    endfunction

    function automatic int eof_pos_w(input int region_size, input int block_size);
        return (region_size * block_size > 1) ? $clog2(region_size * block_size) : 1;
    endfunction

    // Value of the LFSR after n single-step advances.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int k = 0; k < n; k++) r = {^(r & LFSR_TAPS), r[15:1]};
        return r;
    endfunction

endpackage

// File: rtl/mfb_frame_gen_lfsr.sv
// mfb_frame_gen_lfsr: 16-bit Fibonacci LFSR with reset value SEED.
//   clk, reset : clock, synchronous active-high reset (loads SEED)
//   en         : advance enable
//   steps      : number of single steps to advance when en is high
//   ahead[k]   : current value advanced by k steps (ahead[0] = current)
// Several frames may start in one word when REGIONS > 1, so the register
// exposes look-ahead values and can jump by up to STEPS positions at once.
module mfb_frame_gen_lfsr
    import mfb_frame_gen_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          STEPS = 1,
    localparam int         SCW   = $clog2(STEPS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [SCW-1:0]         steps,
    output logic [STEPS:0][15:0]   ahead
);

    logic [15:0] q;

    always_ff @(posedge clk) begin
        if (reset) q <= SEED;
        else if (en) q <= ahead[steps];
    end

    always_comb begin
        for (int k = 0; k <= STEPS; k++) ahead[k] = lfsr_adv(q, k);
    end

endmodule

// File: rtl/mfb_frame_gen.sv
// mfb_frame_gen: MFB frame source for hardware self-tests.
//   CLK, RESET        : clock, synchronous active-high reset
//   START             : start pulse (accepted only in IDLE)
//   FRAMES            : number of frames to emit (sampled on START)
//   LEN_MIN, LEN_MAX  : frame length range in items (sampled on START)
//   BUSY, DONE        : RUN state flag, one-cycle completion pulse
//   SENT_CNT          : EOFs transferred since START (saturating)
//   TX_*              : MFB source interface; frames start at item 0 of a
//                       region and follow back-to-back in region order
module mfb_frame_gen
    import mfb_frame_gen_pkg::*;
#(
    parameter int          REGIONS     = 1,
    parameter int          REGION_SIZE = 8,
    parameter int          BLOCK_SIZE  = 8,
    parameter int          ITEM_WIDTH  = 8,
    parameter int          CNT_WIDTH   = 32,
    parameter int          LEN_WIDTH   = 16,
    parameter logic [15:0] SEED        = 16'hACE1,
    localparam int         R   = REGION_SIZE * BLOCK_SIZE,
    localparam int         DW  = REGIONS * R * ITEM_WIDTH,
    localparam int         SW  = sof_pos_w(REGION_SIZE),
    localparam int         EW  = eof_pos_w(REGION_SIZE, BLOCK_SIZE),
    localparam int         SCW = $clog2(REGIONS + 1)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic [CNT_WIDTH-1:0]    FRAMES,
    input  logic [LEN_WIDTH-1:0]    LEN_MIN,
    input  logic [LEN_WIDTH-1:0]    LEN_MAX,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [CNT_WIDTH-1:0]    SENT_CNT,
    output logic [DW-1:0]           TX_DATA,
    output logic [REGIONS*SW-1:0]   TX_SOF_POS,
    output logic [REGIONS*EW-1:0]   TX_EOF_POS,
    output logic [REGIONS-1:0]      TX_SOF,
    output logic [REGIONS-1:0]      TX_EOF,
    output logic                    TX_SRC_RDY,
    input  logic                    TX_DST_RDY
);

    state_t state, nxt;

    logic [LEN_WIDTH-1:0] len_min_q, len_max_q, mask_q;
    logic                 span_q;      // LEN_MIN < LEN_MAX: lengths are randomised
    logic [CNT_WIDTH-1:0] left_q;      // frames not yet started
    logic [CNT_WIDTH-1:0] fidx_q;      // index of the frame in flight / next frame
    logic [LEN_WIDTH-1:0] rem_q;       // items of the current frame still to emit
    logic [LEN_WIDTH-1:0] off_q;       // frame offset of the next region's item 0
    logic                 in_frm_q;
    logic                 last_q;      // presented word carries the final EOF

    logic start_ok, xfer, load;
    assign start_ok = (state == ST_IDLE) && START;
    assign xfer     = TX_SRC_RDY && TX_DST_RDY;
    // A new word is built whenever the output register is empty or being drained,
    // until the word with the final EOF has been loaded.
    assign load     = (state == ST_RUN) && !last_q && (!TX_SRC_RDY || TX_DST_RDY);

    // Fill chain results
    logic [REGIONS-1:0]       sof_n, eof_n;
    logic [REGIONS*EW-1:0]    eofpos_n;
    logic [DW-1:0]            data_n;
    logic                     c_in;
    logic [LEN_WIDTH-1:0]     c_rem, c_off;
    logic [CNT_WIDTH-1:0]     c_fidx, c_left;
    logic [SCW-1:0]           c_steps;
    logic [REGIONS:0][15:0]   lfsr_ahead;

    mfb_frame_gen_lfsr #(.SEED(SEED), .STEPS(REGIONS)) lfsr_i (
        .clk   (CLK),
        .reset (RESET),
        .en    (load),
        .steps (c_steps),
        .ahead (lfsr_ahead)
    );

    // Smallest 2^k-1 covering d: smear the top set bit downwards.
    function automatic logic [LEN_WIDTH-1:0] smear(input logic [LEN_WIDTH-1:0] d);
        logic [LEN_WIDTH-1:0] m;
        m = d;
        for (int s = 1; s < LEN_WIDTH; s = s * 2) m = m | (m >> s);
        return m;
    endfunction

    function automatic logic [LEN_WIDTH-1:0] pick_len(input logic [15:0] rnd);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, len_min_q} + {1'b0, LEN_WIDTH'(rnd) & mask_q};
        if (!span_q) return len_min_q;
        return (sum > {1'b0, len_max_q}) ? len_max_q : sum[LEN_WIDTH-1:0];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (START) nxt = (FRAMES == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (xfer && last_q) nxt = ST_DONE;
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == ST_RUN);
        DONE = (state == ST_DONE);
    end

    // ---------------- region fill chain ----------------
    // Walks the regions of one word in order: an empty region starts the next
    // frame (if any remain), an occupied region emits up to R items of it.
    always_comb begin
        sof_n    = '0;
        eof_n    = '0;
        eofpos_n = '0;
        data_n   = '0;
        c_in     = in_frm_q;
        c_rem    = rem_q;
        c_off    = off_q;
        c_fidx   = fidx_q;
        c_left   = left_q;
        c_steps  = '0;
        for (int r = 0; r < REGIONS; r++) begin
            if (!c_in && c_left != '0) begin
                c_rem    = pick_len(lfsr_ahead[c_steps]);
                c_off    = '0;
                c_in     = 1'b1;
                c_left   = c_left - 1'b1;
                c_steps  = c_steps + 1'b1;
                sof_n[r] = 1'b1;
            end
            if (c_in) begin
                for (int i = 0; i < R; i++) begin
                    if (i < int'(c_rem))
                        data_n[(r*R+i)*ITEM_WIDTH +: ITEM_WIDTH] =
                            ITEM_WIDTH'(c_fidx) + ITEM_WIDTH'(c_off) + ITEM_WIDTH'(i);
                end
                if (int'(c_rem) <= R) begin
                    eof_n[r]             = 1'b1;
                    eofpos_n[r*EW +: EW] = EW'(c_rem - 1'b1);
                    c_in                 = 1'b0;
                    c_fidx               = c_fidx + 1'b1;
                end else begin
                    c_rem = c_rem - LEN_WIDTH'(R);
                    c_off = c_off + LEN_WIDTH'(R);
                end
            end
        end
    end

    assign TX_SOF_POS = '0;

    // ---------------- datapath / output register ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            len_min_q  <= '0;
            len_max_q  <= '0;
            mask_q     <= '0;
            span_q     <= 1'b0;
            left_q     <= '0;
            fidx_q     <= '0;
            rem_q      <= '0;
            off_q      <= '0;
            in_frm_q   <= 1'b0;
            last_q     <= 1'b0;
            SENT_CNT   <= '0;
            TX_DATA    <= '0;
            TX_EOF_POS <= '0;
            TX_SOF     <= '0;
            TX_EOF     <= '0;
            TX_SRC_RDY <= 1'b0;
        end else begin
            if (start_ok) begin
                len_min_q <= LEN_MIN;
                len_max_q <= LEN_MAX;
                span_q    <= LEN_MIN < LEN_MAX;
                mask_q    <= smear(LEN_MAX - LEN_MIN);
                left_q    <= FRAMES;
                fidx_q    <= '0;
                in_frm_q  <= 1'b0;
                last_q    <= 1'b0;
                SENT_CNT  <= '0;
            end else if (xfer) begin
                logic [CNT_WIDTH:0] sum;
                sum = {1'b0, SENT_CNT} + (CNT_WIDTH+1)'($countones(TX_EOF));
                SENT_CNT <= sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
            end

            if (load) begin
                TX_DATA    <= data_n;
                TX_EOF_POS <= eofpos_n;
                TX_SOF     <= sof_n;
                TX_EOF     <= eof_n;
                TX_SRC_RDY <= 1'b1;
                in_frm_q   <= c_in;
                rem_q      <= c_rem;
                off_q      <= c_off;
                fidx_q     <= c_fidx;
                left_q     <= c_left;
                last_q     <= !c_in && (c_left == '0);
            end else if (xfer) begin
                TX_DATA    <= '0;
                TX_EOF_POS <= '0;
                TX_SOF     <= '0;
                TX_EOF     <= '0;
                TX_SRC_RDY <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mfb_frame_gen.sv
// tb_mfb_frame_gen: table-driven directed runs plus randomised runs, all
// checked by a frame-level reference model (expected length list per START,
// data pattern (frame_index + offset) mod 256) and a stall-stability monitor.
module tb_mfb_frame_gen;

    localparam int REGIONS = 1, REGION_SIZE = 8, BLOCK_SIZE = 8, ITEM_WIDTH = 8;
    localparam int CNT_WIDTH = 32, LEN_WIDTH = 16;
    localparam int R  = REGION_SIZE * BLOCK_SIZE;
    localparam int DW = REGIONS * R * ITEM_WIDTH;
    localparam int SW = 3, EW = 6;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                  CLK = 1'b0;
    logic                  RESET, START, BUSY, DONE, TX_SRC_RDY, TX_DST_RDY;
    logic [CNT_WIDTH-1:0]  FRAMES, SENT_CNT;
    logic [LEN_WIDTH-1:0]  LEN_MIN, LEN_MAX;
    logic [DW-1:0]         TX_DATA;
    logic [REGIONS*SW-1:0] TX_SOF_POS;
    logic [REGIONS*EW-1:0] TX_EOF_POS;
    logic [REGIONS-1:0]    TX_SOF, TX_EOF;

    mfb_frame_gen #(
        .REGIONS(REGIONS), .REGION_SIZE(REGION_SIZE), .BLOCK_SIZE(BLOCK_SIZE),
        .ITEM_WIDTH(ITEM_WIDTH), .CNT_WIDTH(CNT_WIDTH), .LEN_WIDTH(LEN_WIDTH), .SEED(SEED)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FRAMES(FRAMES),
        .LEN_MIN(LEN_MIN), .LEN_MAX(LEN_MAX), .BUSY(BUSY), .DONE(DONE),
        .SENT_CNT(SENT_CNT), .TX_DATA(TX_DATA), .TX_SOF_POS(TX_SOF_POS),
        .TX_EOF_POS(TX_EOF_POS), .TX_SOF(TX_SOF), .TX_EOF(TX_EOF),
        .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int frames; int lmin; int lmax; int mode; int exp_words; int exp_sent;
    } vec_t;

    int checks = 0, errors = 0;
    int cyc = 0, dst_mode = 0, pat = 0;

    // reference model / monitor state
    bit [15:0] m_lfsr = SEED;
    int  exp_q[$];
    bit  in_frame = 0;
    int  cur_len, off, fidx, frames_seen, words, last_xfer_cyc, item64;
    int  obs_min, obs_max;
    bit  prev_stall = 0;
    logic [DW+2*REGIONS+REGIONS*EW:0] saved;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit [15:0] lfsr_next(input bit [15:0] l);
        bit b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction

    // Expected lengths for a START, consuming one LFSR value per frame.
    task automatic model_start(input int f, input int lmin, input int lmax);
        int mask, len;
        exp_q.delete();
        fidx = 0; frames_seen = 0; words = 0; in_frame = 0;
        mask = 0;
        if (lmax > lmin) while (mask < lmax - lmin) mask = mask * 2 + 1;
        for (int k = 0; k < f; k++) begin
            if (lmin >= lmax) len = lmin;
            else begin
                len = lmin + (int'(m_lfsr) & mask);
                if (len > lmax) len = lmax;
            end
            exp_q.push_back(len);
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic monitor();
        logic [DW+2*REGIONS+REGIONS*EW:0] now;
        now = {TX_SRC_RDY, TX_DATA, TX_SOF, TX_EOF, TX_EOF_POS};
        if (RESET) begin
            in_frame = 0; prev_stall = 0; exp_q.delete();
            return;
        end
        if (prev_stall) chk("stall_hold", (now == saved), 1);
        prev_stall = TX_SRC_RDY && !TX_DST_RDY;
        saved = now;
        if (!(TX_SRC_RDY && TX_DST_RDY)) return;
        words++;
        last_xfer_cyc = cyc;
        for (int r = 0; r < REGIONS; r++) begin
            int n, bad, ep, e;
            ep = int'(TX_EOF_POS[r*EW +: EW]);
            if (!in_frame) begin
                if (TX_SOF[r]) begin
                    if (exp_q.size() == 0) begin chk("extra_sof", 1, 0); cur_len = 0; end
                    else cur_len = exp_q.pop_front();
                    chk("sof_pos", TX_SOF_POS[r*SW +: SW], 0);
                    in_frame = 1; off = 0;
                end else begin
                    chk("idle_region_ok", (exp_q.size() == 0) && !TX_EOF[r], 1);
                end
            end
            if (in_frame) begin
                n = TX_EOF[r] ? ep + 1 : R;
                bad = 0;
                for (int i = 0; i < R; i++) begin
                    e = (i < n) ? ((fidx + off + i) & 255) : 0;
                    if (int'(TX_DATA[(r*R+i)*8 +: 8]) != e) bad++;
                end
                chk("data_items_bad", bad, 0);
                if (fidx == 1 && off <= 64 && 64 < off + n)
                    item64 = int'(TX_DATA[(r*R + 64 - off)*8 +: 8]);
                off += n;
                if (TX_EOF[r]) begin
                    chk("frame_len", off, cur_len);
                    if (off < obs_min) obs_min = off;
                    if (off > obs_max) obs_max = off;
                    fidx++; frames_seen++; in_frame = 0;
                end
            end
        end
    endtask

    // Advance one cycle: drive DST_RDY just after the edge, observe at negedge.
    task automatic tick();
        @(posedge CLK);
        cyc++;
        #1;
        case (dst_mode)
            0: TX_DST_RDY = 1'b1;
            1: begin TX_DST_RDY = (pat % 3 == 0); pat++; end
            default: TX_DST_RDY = 1'($urandom_range(0, 1));
        endcase
        @(negedge CLK);
        monitor();
    endtask

    task automatic run_test(input int f, input int lmin, input int lmax, input int mode,
                            input int exp_words, input int exp_sent);
        int n;
        dst_mode = mode; pat = 0;
        model_start(f, lmin, lmax);
        FRAMES = f; LEN_MIN = LEN_WIDTH'(lmin); LEN_MAX = LEN_WIDTH'(lmax);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("busy_t1", BUSY, f > 0);
        chk("done_t1", DONE, f == 0);
        chk("src_rdy_t1", TX_SRC_RDY, 0);
        if (f > 0) begin
            tick();
            chk("first_word_t2", TX_SRC_RDY, 1);
        end
        n = 0;
        while (!DONE && n < 60000) begin tick(); n++; end
        chk("done_seen", DONE, 1);
        chk("busy_at_done", BUSY, 0);
        chk("src_rdy_at_done", TX_SRC_RDY, 0);
        chk("sent_cnt", SENT_CNT, exp_sent);
        chk("frames_seen", frames_seen, f);
        chk("frames_left_in_model", exp_q.size(), 0);
        if (f > 0) chk("done_after_last", cyc, last_xfer_cyc + 1);
        if (exp_words >= 0) chk("words", words, exp_words);
        tick();
        chk("done_pulse_width", DONE, 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        m_lfsr = SEED;
        chk("rst_src_rdy", TX_SRC_RDY, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_sent", SENT_CNT, 0);
        chk("rst_sof_eof", {TX_SOF, TX_EOF}, 0);
        chk("rst_data_zero", TX_DATA == '0, 1);
        chk("rst_eof_pos", TX_EOF_POS, 0);
        RESET = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int f, lmin, lmax;
        RESET = 1'b1; START = 1'b0; FRAMES = '0; LEN_MIN = '0; LEN_MAX = '0;
        TX_DST_RDY = 1'b0;
        tick(); tick();
        do_reset();
        tick();

        vecs[0] = '{4,   64,  64, 0, 4, 4};
        vecs[1] = '{2,   65,  65, 0, 4, 2};
        vecs[2] = '{4,   64,  64, 1, 4, 4};
        vecs[3] = '{0,    5,   9, 0, 0, 0};
        vecs[4] = '{3,    1,   1, 2, 3, 3};
        vecs[5] = '{2,   10,   5, 0, 2, 2};
        vecs[6] = '{1,  129, 129, 2, 3, 1};
        vecs[7] = '{5,   63,  64, 0, 5, 5};
        for (int i = 0; i < 8; i++) begin
            item64 = -1;
            run_test(vecs[i].frames, vecs[i].lmin, vecs[i].lmax, vecs[i].mode,
                     vecs[i].exp_words, vecs[i].exp_sent);
            if (i == 1) chk("frame1_item64", item64, 8'h41);
        end

        for (int k = 0; k < 6; k++) begin
            f    = $urandom_range(1, 40);
            lmin = $urandom_range(1, 300);
            lmax = lmin + $urandom_range(0, 420) - 20;
            run_test(f, lmin, lmax, 2, -1, f);
        end

        obs_min = 1 << 30; obs_max = 0;
        run_test(2000, 60, 512, 2, -1, 2000);
        chk("len_min_bound", obs_min >= 60, 1);
        chk("len_max_bound", obs_max <= 512, 1);

        // abandon a frame mid-transfer, then restart from SEED
        dst_mode = 0;
        model_start(5, 300, 300);
        FRAMES = 5; LEN_MIN = 16'd300; LEN_MAX = 16'd300;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        do_reset();
        tick();
        run_test(3, 60, 512, 2, -1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
